// File: rtl/encoder_conditioner.sv
// Quadrature encoder front end: synchronise and glitch-filter A/B, decode steps,
// keep a signed position, and gate out reverse motion before it reaches the divider.
module encoder_conditioner #(
    parameter int FILT_LEN = 8,
    parameter int BACK_W   = 16
) (
    input  logic              clk_8m,
    input  logic              rst,
    input  logic              enc_a_in,
    input  logic              enc_b_in,
    input  logic              dir_invert,
    input  logic              reverse_gate_en,
    input  logic              clr_cnt,
    output logic              encoder,
    output logic              encoderb,
    output logic              dir,
    output logic [31:0]       pos_cnt,
    output logic [BACK_W-1:0] back_cnt,
    output logic              quad_err
);

    localparam logic [7:0]        FILT_MAX = 8'(FILT_LEN - 1);
    localparam logic [BACK_W-1:0] BACK_MAX = {BACK_W{1'b1}};

    // Bit 1 carries phase A, bit 0 phase B, so filt reads as {A, B}.
    logic [1:0] raw_in;
    logic [1:0] filt;

    assign raw_in = {enc_a_in, enc_b_in};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic       s1_q;
            logic       s2_q;
            logic       filt_q;
            logic       filt_d;
            logic [7:0] cnt_q;
            logic [7:0] cnt_d;

            // The filtered value flips only after FILT_LEN consecutive disagreeing samples.
            always_comb begin
                filt_d = filt_q;
                cnt_d  = 8'd0;
                if (s2_q != filt_q) begin
                    if (cnt_q == FILT_MAX) begin
                        filt_d = s2_q;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            always_ff @(posedge clk_8m) begin
                if (rst) begin
                    s1_q   <= 1'b0;
                    s2_q   <= 1'b0;
                    filt_q <= 1'b0;
                    cnt_q  <= 8'd0;
                end else begin
                    s1_q   <= raw_in[gi];
                    s2_q   <= s1_q;
                    filt_q <= filt_d;
                    cnt_q  <= cnt_d;
                end
            end

            assign filt[gi] = filt_q;
        end
    endgenerate

    logic [1:0]        prev_ab_q;
    logic              gate_q;
    logic              enc_q, enc_d;
    logic              encb_q;
    logic              dir_q, dir_d;
    logic [31:0]       pos_q, pos_d;
    logic [BACK_W-1:0] back_q, back_d;
    logic              err_q, err_d;

    logic [3:0] trans;
    logic       fwd_seq;
    logic       rev_seq;
    logic       dbl;
    logic       step_fwd;
    logic       step_rev;
    logic       gate_fall;

    always_comb begin
        trans     = {prev_ab_q, filt};
        fwd_seq   = trans inside {4'b0010, 4'b1011, 4'b1101, 4'b0100};
        rev_seq   = trans inside {4'b1000, 4'b1110, 4'b0111, 4'b0001};
        dbl       = ((prev_ab_q ^ filt) == 2'b11);
        step_fwd  = dir_invert ? rev_seq : fwd_seq;
        step_rev  = dir_invert ? fwd_seq : rev_seq;
        gate_fall = gate_q & ~reverse_gate_en;

        pos_d  = pos_q;
        back_d = back_q;
        err_d  = err_q;
        dir_d  = dir_q;
        enc_d  = reverse_gate_en ? enc_q : filt[1];

        if (clr_cnt) begin
            pos_d  = 32'd0;
            back_d = '0;
            err_d  = 1'b0;
            enc_d  = filt[1];
        end else begin
            if (dbl) begin
                err_d = 1'b1;
            end
            if (step_fwd) begin
                pos_d = pos_q + 32'd1;
                dir_d = 1'b1;
                // Forward steps first pay back outstanding reverse motion.
                if (reverse_gate_en) begin
                    if (back_q != '0) begin
                        back_d = back_q - 1'b1;
                    end else begin
                        enc_d = filt[1];
                    end
                end
            end else if (step_rev) begin
                pos_d = pos_q - 32'd1;
                dir_d = 1'b0;
                if (reverse_gate_en && back_q != BACK_MAX) begin
                    back_d = back_q + 1'b1;
                end
            end
        end

        if (gate_fall) begin
            back_d = '0;
        end
    end

    always_ff @(posedge clk_8m) begin
        if (rst) begin
            prev_ab_q <= 2'b00;
            gate_q    <= 1'b0;
            enc_q     <= 1'b0;
            encb_q    <= 1'b0;
            dir_q     <= 1'b0;
            pos_q     <= 32'd0;
            back_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            prev_ab_q <= filt;
            gate_q    <= reverse_gate_en;
            enc_q     <= enc_d;
            encb_q    <= filt[0];
            dir_q     <= dir_d;
            pos_q     <= pos_d;
            back_q    <= back_d;
            err_q     <= err_d;
        end
    end

    assign encoder  = enc_q;
    assign encoderb = encb_q;
    assign dir      = dir_q;
    assign pos_cnt  = pos_q;
    assign back_cnt = back_q;
    assign quad_err = err_q;

endmodule

// File: tb/tb_encoder_conditioner.sv
// Directed plus randomized bench for encoder_conditioner, checked against a
// quadrature-index model of position, direction, backlash and gated output.
module tb_encoder_conditioner;

    logic        clk_8m = 1'b0;
    logic        rst = 1'b1;
    logic        enc_a_in = 1'b0;
    logic        enc_b_in = 1'b0;
    logic        dir_invert = 1'b0;
    logic        reverse_gate_en = 1'b0;
    logic        clr_cnt = 1'b0;
    logic        encoder;
    logic        encoderb;
    logic        dir;
    logic [31:0] pos_cnt;
    logic [15:0] back_cnt;
    logic        quad_err;

    encoder_conditioner #(.FILT_LEN(8), .BACK_W(16)) dut (
        .clk_8m          (clk_8m),
        .rst             (rst),
        .enc_a_in        (enc_a_in),
        .enc_b_in        (enc_b_in),
        .dir_invert      (dir_invert),
        .reverse_gate_en (reverse_gate_en),
        .clr_cnt         (clr_cnt),
        .encoder         (encoder),
        .encoderb        (encoderb),
        .dir             (dir),
        .pos_cnt         (pos_cnt),
        .back_cnt        (back_cnt),
        .quad_err        (quad_err)
    );

    always #5 clk_8m = ~clk_8m;

    int n_cmp = 0;
    int n_bad = 0;

    // Encoder edge counter, read as before/after differences.
    logic enc_last = 1'b0;
    int   toggles = 0;
    always @(posedge clk_8m) begin
        enc_last <= encoder;
        if (encoder !== enc_last) toggles <= toggles + 1;
    end

    // Model: position along the Gray cycle 00,10,11,01 as index 0..3.
    int          m_idx;
    logic [31:0] m_pos;
    logic        m_dir;
    logic        m_err;
    logic        m_enc;
    int          m_back;

    function automatic logic gray_a(input int i);
        return (i == 1) || (i == 2);
    endfunction

    function automatic logic gray_b(input int i);
        return (i == 2) || (i == 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/pos"},  pos_cnt, m_pos);
        chk({tag, "/dir"},  32'(dir), 32'(m_dir));
        chk({tag, "/err"},  32'(quad_err), 32'(m_err));
        chk({tag, "/back"}, 32'(back_cnt), 32'(m_back));
        chk({tag, "/enc"},  32'(encoder), 32'(m_enc));
        chk({tag, "/encb"}, 32'(encoderb), 32'(gray_b(m_idx)));
    endtask

    task automatic model_reset();
        m_idx = 0; m_pos = 32'd0; m_dir = 1'b0; m_err = 1'b0; m_enc = 1'b0; m_back = 0;
    endtask

    task automatic model_step(input int ni);
        int d;
        bit fwd;
        d = (ni - m_idx) & 3;
        if (d == 2) begin
            m_err = 1'b1;
        end else if (d != 0) begin
            fwd = ((d == 1) != dir_invert);
            if (fwd) begin
                m_pos = m_pos + 32'd1;
                m_dir = 1'b1;
                if (reverse_gate_en) begin
                    if (m_back != 0) m_back--;
                    else m_enc = gray_a(ni);
                end
            end else begin
                m_pos = m_pos - 32'd1;
                m_dir = 1'b0;
                if (reverse_gate_en && m_back < 65535) m_back++;
            end
        end
        m_idx = ni;
        if (!reverse_gate_en) m_enc = gray_a(ni);
    endtask

    task automatic drive_idx(input int i);
        @(negedge clk_8m);
        enc_a_in = gray_a(i);
        enc_b_in = gray_b(i);
    endtask

    task automatic settle();
        repeat (14 + $urandom_range(0, 6)) @(posedge clk_8m);
        @(negedge clk_8m);
    endtask

    task automatic step(input int delta, input string tag);
        int ni;
        ni = (m_idx + delta) & 3;
        drive_idx(ni);
        settle();
        model_step(ni);
        check_all(tag);
    endtask

    task automatic set_gate(input logic g);
        @(negedge clk_8m);
        if (reverse_gate_en && !g) begin
            m_back = 0;
            m_enc  = gray_a(m_idx);
        end
        reverse_gate_en = g;
        repeat (3) @(negedge clk_8m);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk_8m);
        rst = 1'b1;
        enc_a_in = 1'b0;
        enc_b_in = 1'b0;
        @(posedge clk_8m);
        #1;
        chk({tag, "/enc"},  32'(encoder), 32'd0);
        chk({tag, "/encb"}, 32'(encoderb), 32'd0);
        chk({tag, "/dir"},  32'(dir), 32'd0);
        chk({tag, "/pos"},  pos_cnt, 32'd0);
        chk({tag, "/back"}, 32'(back_cnt), 32'd0);
        chk({tag, "/err"},  32'(quad_err), 32'd0);
        @(negedge clk_8m);
        rst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_8m);
    endtask

    initial begin
        int t0;
        int r;
        model_reset();
        repeat (3) @(negedge clk_8m);
        do_reset("reset");

        // Forward motion: exact first-edge latency, then four full cycles.
        t0 = toggles;
        drive_idx(1);
        repeat (10) @(posedge clk_8m);
        #1 chk("lat_e10", 32'(encoder), 32'd0);
        @(posedge clk_8m);
        #1 chk("lat_e11", 32'(encoder), 32'd1);
        settle();
        model_step(1);
        check_all("fwd1");
        for (int i = 0; i < 15; i++) step(1, "fwd");
        chk("fwd_pos16", pos_cnt, 32'd16);
        chk("fwd_toggles", 32'(toggles - t0), 32'd8);

        // Glitch filter: a 7-cycle pulse vanishes, an 8-cycle pulse passes.
        @(negedge clk_8m);
        enc_a_in = 1'b1;
        repeat (7) @(negedge clk_8m);
        enc_a_in = 1'b0;
        settle();
        check_all("glitch7");
        @(negedge clk_8m);
        enc_a_in = 1'b1;
        repeat (8) @(negedge clk_8m);
        enc_a_in = 1'b0;
        repeat (3) @(posedge clk_8m);
        #1;
        chk("glitch8/enc", 32'(encoder), 32'd1);
        chk("glitch8/pos", pos_cnt, m_pos + 32'd1);
        settle();
        model_step(1);
        model_step(0);
        check_all("glitch8_back");

        // Backlash gating: 8 forward, 6 reverse, 10 forward.
        set_gate(1'b1);
        t0 = toggles;
        for (int i = 0; i < 8; i++) step(1, "gate_f8");
        chk("gate_tog8", 32'(toggles - t0), 32'd4);
        t0 = toggles;
        for (int i = 0; i < 6; i++) step(-1, "gate_r6");
        chk("gate_back6", 32'(back_cnt), 32'd6);
        for (int i = 0; i < 6; i++) step(1, "gate_retrav");
        chk("gate_tog_absorbed", 32'(toggles - t0), 32'd0);
        t0 = toggles;
        for (int i = 0; i < 4; i++) step(1, "gate_f4");
        chk("gate_tog2", 32'(toggles - t0), 32'd2);
        set_gate(1'b0);

        // Double transition, then a clear that swallows a same-cycle step.
        step(2, "dbl");
        chk("dbl_err", 32'(quad_err), 32'd1);
        r = (m_idx + 1) & 3;
        drive_idx(r);
        repeat (10) @(posedge clk_8m);
        @(negedge clk_8m);
        clr_cnt = 1'b1;
        @(negedge clk_8m);
        clr_cnt = 1'b0;
        settle();
        m_idx = r; m_pos = 32'd0; m_err = 1'b0; m_back = 0; m_enc = gray_a(r);
        check_all("clr_step");

        // Inverted direction: B-leads-A counts forward.
        dir_invert = 1'b1;
        for (int i = 0; i < 4; i++) step(-1, "inv");
        chk("inv_dir", 32'(dir), 32'd1);
        @(negedge clk_8m);
        force dut.pos_q = 32'h7FFF_FFFF;
        @(negedge clk_8m);
        release dut.pos_q;
        m_pos = 32'h7FFF_FFFF;
        step(-1, "wrap");
        chk("wrap_pos", pos_cnt, 32'h8000_0000);
        dir_invert = 1'b0;

        // Reset mid-motion with outstanding backlash.
        set_gate(1'b1);
        for (int i = 0; i < 3; i++) step(-1, "pre_rst");
        do_reset("rst_mid");

        // Dropping the gate flushes backlash and resumes tracking A.
        for (int i = 0; i < 5; i++) step(-1, "pre_drop");
        set_gate(1'b0);
        check_all("gate_drop");

        // Randomized motion.
        for (int i = 0; i < 90; i++) begin
            r = $urandom_range(0, 99);
            if (r < 45) step(1, "rnd_f");
            else if (r < 85) step(-1, "rnd_r");
            else if (r < 89) step(2, "rnd_dbl");
            else if (r < 95) begin
                set_gate(~reverse_gate_en);
                check_all("rnd_gate");
            end else if (r < 98) begin
                dir_invert = ~dir_invert;
            end else begin
                @(negedge clk_8m);
                clr_cnt = 1'b1;
                @(negedge clk_8m);
                clr_cnt = 1'b0;
                m_pos = 32'd0; m_err = 1'b0; m_back = 0; m_enc = gray_a(m_idx);
                repeat (2) @(negedge clk_8m);
                check_all("rnd_clr");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
